// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state type and frame length helper.
// The future configurable receiver imports this package as well.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Start bit + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Symbol-time counter: counts while enabled, clears on request and flags the last
// cycle of each symbol so the owner can advance to the next bit.
module uart_baud_tick #(
  parameter int SYMBOL_TIME = 1085
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic symbol_edge_o
);

  localparam int CNT_W = (SYMBOL_TIME > 1) ? $clog2(SYMBOL_TIME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign symbol_edge_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = symbol_edge_o ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter_cfg.sv
// Configurable UART transmitter with a one-entry holding buffer so that frames
// stream back-to-back from a ready/valid byte source onto the TX pin.
module uart_transmitter_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int FRAME_BITS  = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int BIT_CNT_W   = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_transmitter_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_transmitter_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter_cfg: STOP_BITS must be 1 or 2");
  end
  if (SYMBOL_TIME < 2) begin : g_bad_symbol_time
    $error("uart_transmitter_cfg: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  // Reset asserts immediately and releases two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  tx_state_e             state_q, state_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  symbol_edge;
  logic                  fire;
  logic                  last_bit;

  // Whole frame laid out LSB-first; shifting right puts each bit on serial_out.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_BITS:1] = d;
    if (PARITY == PARITY_EVEN) begin
      f[DATA_BITS+1] = ^d;
    end else if (PARITY == PARITY_ODD) begin
      f[DATA_BITS+1] = ~^d;
    end
    return f;
  endfunction

  uart_baud_tick #(
    .SYMBOL_TIME(SYMBOL_TIME)
  ) u_baud_tick (
    .clk          (clk),
    .reset_n      (rst_n_int),
    .en_i         (busy),
    .clr_i        (!busy),
    .symbol_edge_o(symbol_edge)
  );

  assign busy          = (state_q == TX_SEND);
  assign data_in_ready = !hold_full_q;
  assign serial_out    = busy ? shift_q[0] : 1'b1;
  assign fire          = data_in_valid && data_in_ready;
  assign last_bit      = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_done  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (fire) begin
          shift_d   = build_frame(data_in);
          bit_cnt_d = '0;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (symbol_edge && last_bit) begin
          frame_done = 1'b1;
          bit_cnt_d  = '0;
          // Ready is low whenever the hold is full, so a fire here implies an empty hold.
          if (hold_full_q) begin
            shift_d     = build_frame(hold_q);
            hold_full_d = 1'b0;
          end else if (fire) begin
            shift_d = build_frame(data_in);
          end else begin
            shift_d = '1;
            state_d = TX_IDLE;
          end
        end else begin
          if (symbol_edge) begin
            shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
          if (fire) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '1;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

endmodule
